ctrl_sequencer: RTL

//   Issues control codes to the REG_BANK/KGP_ALU datapath. The datapath only consumes one 3-bit

---
 rtl/ctrl_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: loads a small program RAM while idle and plays it back as one control code per cycle.
// Optional macro SEQ_HOLD_EN adds a hold input that stalls playback in RUN.
module ctrl_sequencer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [CW:0]   prog_data,
   input  logic          start,
`ifdef SEQ_HOLD_EN
   input  logic          hold,
`endif
   output logic [CW-1:0] control,
   output logic          ctrl_valid,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] pc
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [CW:0] mem [DEPTH];
   logic        stall;

`ifdef SEQ_HOLD_EN
   always_comb stall = hold;
`else
   always_comb stall = 1'b0;
`endif

   // Program RAM is never reset; writes land only while idle and inside the table.
   always_ff @(posedge clk) begin
      if (!rst && state == IDLE && prog_we && 32'(prog_addr) < DEPTH)
         mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         control    <= '0;
         ctrl_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pc         <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               control    <= '0;
               ctrl_valid <= 1'b0;
               done       <= 1'b0;
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  pc    <= '0;
               end
            end
            RUN: begin
               if (stall) begin
                  ctrl_valid <= 1'b0;
               end else begin
                  control    <= mem[pc][CW-1:0];
                  ctrl_valid <= 1'b1;
                  if (mem[pc][CW] || 32'(pc) == DEPTH - 1)
                     state <= DONE;
                  else
                     pc <= pc + 1'b1;
               end
            end
            DONE: begin
               // First edge raises the done pulse, second edge returns to IDLE.
               control    <= '0;
               ctrl_valid <= 1'b0;
               if (!done) begin
                  done <= 1'b1;
               end else begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  pc    <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
